// File: rtl/u_reg_pkg.sv
// Shared definitions for the image-pipe register slave: register map, field positions,
// FSM state encoding and the value returned on a read miss.
package u_reg_pkg;

  // Register offsets within the 256-byte block
  localparam logic [7:0] OffCtrl    = 8'h00;
  localparam logic [7:0] OffStatus  = 8'h04;
  localparam logic [7:0] OffImgSize = 8'h08;
  localparam logic [7:0] OffIrqStat = 8'h0C;
  localparam logic [7:0] OffIrqMask = 8'h10;
  localparam logic [7:0] OffScratch = 8'h14;
  localparam logic [7:0] OffVersion = 8'h18;

  // Field positions
  localparam int unsigned CtrlEnBit     = 0;
  localparam int unsigned CtrlStartBit  = 1;
  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned IrqW          = 4;

  // Returned for unmapped offsets or a base mismatch
  localparam logic [31:0] MissRdata = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    StIdle,
    StWack,
    StRdWait,
    StRdv,
    StRelease
  } state_e;

endpackage

// File: rtl/u_reg_slave.sv
// Target end of the image-pipe CPU register bus. Holds the control/status register bank,
// drives the pipe configuration outputs and a registered interrupt line.
module u_reg_slave
  import u_reg_pkg::*;
#(
  parameter int unsigned    AW      = 32,
  parameter int unsigned    DW      = 32,
  parameter logic [AW-1:0]  BASE    = '0,
  parameter int unsigned    RD_LAT  = 1,
  parameter logic [31:0]    VERSION = 32'h0001_0000
) (
  input  logic            u_clk,
  input  logic            u_rst,
  input  logic            u_cs,
  input  logic [AW-1:0]   u_addr,
  input  logic [DW-1:0]   u_data_wr,
  input  logic            u_we,
  input  logic            u_re,
  output logic            u_wack,
  output logic            u_rdv,
  output logic [DW-1:0]   u_data_rd,
  output logic            ctrl_en,
  output logic            ctrl_start,
  output logic [15:0]     img_width,
  output logic [15:0]     img_height,
  input  logic            sts_busy,
  input  logic [IrqW-1:0] irq_set,
  output logic            irq
);

  if (DW != 32) begin : g_bad_dw
    $error("u_reg_slave: DW must be 32");
  end
  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("u_reg_slave: RD_LAT must be in 1..15");
  end

  // RD_WAIT lasts RD_LAT-1 cycles; the counter reaches 0 in its last one
  localparam logic [3:0] WaitInit = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ctrl_en_q, ctrl_en_d;
  logic            start_q, start_d;
  logic [31:0]     img_size_q, img_size_d;
  logic [IrqW-1:0] irq_stat_q, irq_stat_d;
  logic [IrqW-1:0] irq_mask_q, irq_mask_d;
  logic [31:0]     scratch_q, scratch_d;
  logic            irq_q, irq_d;

  logic            base_hit;
  logic [7:0]      offset;
  logic            wr_acc, rd_acc, wr_hit;
  logic [31:0]     rd_word;
  logic [IrqW-1:0] irq_clr;
  logic            unused_addr_lsb;

  assign base_hit        = (u_addr[AW-1:8] == BASE[AW-1:8]);
  assign offset          = {u_addr[7:2], 2'b00};
  assign unused_addr_lsb = ^u_addr[1:0];

  // A read with u_we also set is treated as a write
  assign wr_acc = (state_q == StIdle) && u_cs && u_we;
  assign rd_acc = (state_q == StIdle) && u_cs && u_re && !u_we;
  assign wr_hit = wr_acc && base_hit;

  // Read mux over current register contents; misses return the marker word
  always_comb begin
    rd_word = MissRdata;
    if (base_hit) begin
      case (offset)
        OffCtrl:    rd_word = {31'b0, ctrl_en_q};
        OffStatus:  rd_word = {31'b0, sts_busy};
        OffImgSize: rd_word = img_size_q;
        OffIrqStat: rd_word = {{(32 - IrqW){1'b0}}, irq_stat_q};
        OffIrqMask: rd_word = {{(32 - IrqW){1'b0}}, irq_mask_q};
        OffScratch: rd_word = scratch_q;
        OffVersion: rd_word = VERSION;
        default:    rd_word = MissRdata;
      endcase
    end
  end

  // Register bank next-state; irq_set is applied after the W1C so a same-cycle set wins
  always_comb begin
    ctrl_en_d  = ctrl_en_q;
    img_size_d = img_size_q;
    irq_mask_d = irq_mask_q;
    scratch_d  = scratch_q;
    irq_clr    = '0;
    start_d    = 1'b0;
    if (wr_hit) begin
      case (offset)
        OffCtrl: begin
          ctrl_en_d = u_data_wr[CtrlEnBit];
          start_d   = u_data_wr[CtrlStartBit];
        end
        OffImgSize: img_size_d = u_data_wr;
        OffIrqStat: irq_clr    = u_data_wr[IrqW-1:0];
        OffIrqMask: irq_mask_d = u_data_wr[IrqW-1:0];
        OffScratch: scratch_d  = u_data_wr;
        default:    ;
      endcase
    end
    irq_stat_d = (irq_stat_q & ~irq_clr) | irq_set;
    irq_d      = |(irq_stat_q & irq_mask_q);
  end

  // Bus handshake FSM next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (wr_acc) begin
          state_d = StWack;
        end else if (rd_acc) begin
          rdata_d = rd_word;
          cnt_d   = WaitInit;
          state_d = (RD_LAT == 1) ? StRdv : StRdWait;
        end
      end
      StWack: state_d = StRelease;
      StRdWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StRdv;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRdv: state_d = StRelease;
      StRelease: begin
        if (!u_cs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and register bank, synchronous reset drops any in-flight access
  always_ff @(posedge u_clk) begin
    if (u_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rdata_q    <= '0;
      ctrl_en_q  <= 1'b0;
      start_q    <= 1'b0;
      img_size_q <= '0;
      irq_stat_q <= '0;
      irq_mask_q <= '0;
      scratch_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      ctrl_en_q  <= ctrl_en_d;
      start_q    <= start_d;
      img_size_q <= img_size_d;
      irq_stat_q <= irq_stat_d;
      irq_mask_q <= irq_mask_d;
      scratch_q  <= scratch_d;
      irq_q      <= irq_d;
    end
  end

  assign u_wack     = (state_q == StWack);
  assign u_rdv      = (state_q == StRdv);
  assign u_data_rd  = u_rdv ? rdata_q : '0;
  assign ctrl_en    = ctrl_en_q;
  assign ctrl_start = start_q;
  assign img_width  = img_size_q[15:0];
  assign img_height = img_size_q[31:16];
  assign irq        = irq_q;

endmodule
